// File: rtl/barcode_rdr.sv
// barcode_rdr: IR barcode station-ID reader; measures start-pulse width T, then samples each
// data bit T cycles after its falling edge. Define BARCODE_ID_FILTER_EN to drop IDs with ID[7:6] != 0.
module barcode_rdr #(
    parameter int CNT_W = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_FALL,
        SAMPLE,
        WAIT_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_bc_ff1;
    logic             r_bc_ff2;
    logic             r_bc_ff3;
    logic             w_bc_s;
    logic             w_bc_fall;
    logic             w_bc_rise;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       w_bit_cnt_nxt;
    logic             w_done;
    logic             w_accept;
    logic [7:0]       r_id;
    logic             r_id_vld;

    // NOTE: the line idles high, so the synchronizer resets to 1 to avoid a false falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bc_ff1 <= 1'b1;
            r_bc_ff2 <= 1'b1;
            r_bc_ff3 <= 1'b1;
        end else begin
            r_bc_ff1 <= BC;
            r_bc_ff2 <= r_bc_ff1;
            r_bc_ff3 <= r_bc_ff2;
        end
    end

    assign w_bc_s    = r_bc_ff2;
    assign w_bc_fall = r_bc_ff3 & ~r_bc_ff2;
    assign w_bc_rise = ~r_bc_ff3 & r_bc_ff2;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_period  <= w_period_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_period_nxt  = r_period;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_bc_fall) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                // A stuck-low line saturates the counter; that is not a frame.
                if (r_cnt == CNT_MAX) begin
                    w_state_nxt = IDLE;
                end else if (w_bc_rise) begin
                    w_period_nxt  = r_cnt;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = (r_cnt < CNT_W'(2)) ? IDLE : WAIT_FALL;
                end else if (!w_bc_s) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            WAIT_FALL: begin
                if (w_bc_fall) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_cnt == r_period) begin
                    w_shift_nxt   = {r_shift[6:0], w_bc_s};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_state_nxt   = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (w_bc_s) begin
                    if (r_bit_cnt < 4'd8) begin
                        w_state_nxt = WAIT_FALL;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef BARCODE_ID_FILTER_EN
    assign w_accept = w_done && (r_shift[7:6] == 2'b00);
`else
    assign w_accept = w_done;
`endif

    // Completion has priority over the acknowledge so a fresh ID is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id     <= 8'h00;
            r_id_vld <= 1'b0;
        end else if (w_accept) begin
            r_id     <= r_shift;
            r_id_vld <= 1'b1;
        end else if (clr_ID_vld) begin
            r_id_vld <= 1'b0;
        end
    end

    assign ID     = r_id;
    assign ID_vld = r_id_vld;

endmodule

// File: tb/tb_barcode_rdr.sv
// tb_barcode_rdr: directed frames for barcode_rdr with hand-computed IDs; CNT_W reduced to 11
// so the stuck-low saturation case stays short.
module tb_barcode_rdr;

    localparam int CW = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic       BC;
    logic       clr_ID_vld;
    logic [7:0] ID;
    logic       ID_vld;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int clr_at = -1;
    int last_fall = 0;
    int vld_rise_cyc = -1;
    bit vld_q = 1'b0;
    bit vld_low_seen = 1'b0;

    barcode_rdr #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ID_vld && !vld_q) vld_rise_cyc = cyc;
        if (!ID_vld) vld_low_seen = 1'b1;
        vld_q = ID_vld;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus, applied just after a falling edge.
    task automatic tick(input logic bc);
        BC         = bc;
        clr_ID_vld = (cyc == clr_at);
        @(negedge clk);
    endtask

    // Bit 1: short low then long high; bit 0: low past the T sample point then short high.
    task automatic send_bit(input logic b, input int t, input bit last, input bit arm);
        int low;
        int high;
        int fall;
        low  = b ? t / 4 : (5 * t) / 4;
        high = b ? t : t / 4;
        fall = cyc;
        if (last) last_fall = fall;
        if (last && arm) clr_at = b ? fall + t + 3 : fall + low + 2;
        repeat (low) tick(1'b0);
        repeat (high) tick(1'b1);
    endtask

    task automatic send_start(input int t);
        repeat (t) tick(1'b0);
        repeat (t / 4) tick(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] id, input int t, input bit arm);
        send_start(t);
        for (int i = 7; i >= 0; i--) send_bit(id[i], t, (i == 0), arm);
        repeat (8) tick(1'b1);
        clr_at = -1;
    endtask

    task automatic pulse_clr();
        clr_at = cyc;
        tick(1'b1);
    endtask

    initial begin
        int lat;
        rst        = 1'b1;
        BC         = 1'b1;
        clr_ID_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_id", ID, 8'h00);
        check("rst_vld", ID_vld, 0);
        rst = 1'b0;
        repeat (4) tick(1'b1);

        // Basic frame and completion latency.
        send_frame(8'h15, 'h20A, 1'b0);
        check("f15_id", ID, 8'h15);
        check("f15_vld", ID_vld, 1);
        lat = vld_rise_cyc - last_fall;
        check("f15_latency_le_T4", int'(lat >= 'h20A && lat <= 'h20A + 4), 1);
        vld_low_seen = 1'b0;
        repeat (50) tick(1'b1);
        check("f15_vld_held", vld_low_seen, 0);

        // Acknowledge, then acknowledge colliding with completion.
        pulse_clr();
        check("clr_vld", ID_vld, 0);
        check("clr_id_hold", ID, 8'h15);
        tick(1'b1);
        send_frame(8'h2A, 'h20A, 1'b1);
        check("f2a_clr_same_cycle_id", ID, 8'h2A);
        check("f2a_clr_same_cycle_vld", ID_vld, 1);

        // ID with upper bits set.
        pulse_clr();
        tick(1'b1);
        send_frame(8'hC5, 'h20A, 1'b0);
`ifdef BARCODE_ID_FILTER_EN
        check("fc5_id", ID, 8'h2A);
        check("fc5_vld", ID_vld, 0);
`else
        check("fc5_id", ID, 8'hC5);
        check("fc5_vld", ID_vld, 1);
`endif

        // Back-to-back frames with different T and no acknowledge.
        send_frame(8'h01, 'h100, 1'b0);
        check("f01_id", ID, 8'h01);
        check("f01_vld", ID_vld, 1);
        vld_low_seen = 1'b0;
        send_frame(8'h3E, 'h3FF, 1'b0);
        check("f3e_id", ID, 8'h3E);
        check("f3e_vld_held", vld_low_seen, 0);

        // Reset after the 4th bit of a frame, then a clean frame.
        send_start('h20A);
        for (int i = 7; i >= 4; i--) send_bit(1'(8'h15 >> i), 'h20A, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_id", ID, 8'h00);
        check("rst_mid_vld", ID_vld, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) tick(1'b1);
        send_frame(8'h22, 'h20A, 1'b0);
        check("f22_id", ID, 8'h22);
        check("f22_vld", ID_vld, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_id", ID, 8'h00);
        check("rst_async_vld", ID_vld, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick(1'b1);

        // Glitches: single-cycle low and stuck-low beyond counter range.
        tick(1'b0);
        repeat (20) tick(1'b1);
        check("glitch_1cyc_vld", ID_vld, 0);
        repeat ((1 << CW) + 10) tick(1'b0);
        repeat (20) tick(1'b1);
        check("stuck_low_vld", ID_vld, 0);
        send_frame(8'h1A, 'h100, 1'b0);
        check("recover_id", ID, 8'h1A);
        check("recover_vld", ID_vld, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/barcode_rdr.md
BARCODE_RDR -- requirements
Module: barcode_rdr

Interface
REQ-001 Parameter CNT_W, default 22; width of the period measurement and bit-timing counters.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 BC  input  1  raw barcode serial line from the IR barcode sensor; asynchronous to clk; idles high.
REQ-005 clr_ID_vld  input  1  single-cycle pulse from the command controller; acknowledges the held ID.
REQ-006 ID  output  8  last accepted station ID, MSB first as received.
REQ-007 ID_vld  output  1  high while an accepted, unacknowledged ID is held.

Function
REQ-008 BC SHALL pass through a 2-flop synchronizer, then a third flop for edge detection; all decoding uses the synchronized signal BC_s.
REQ-009 Frame format: a start pulse (BC low for T cycles), then 8 data bits; each bit begins with a BC falling edge; the bit value is BC_s sampled T cycles after that edge (low = 0, high = 1).
REQ-010 The FSM SHALL have states IDLE, START, WAIT_FALL, SAMPLE and WAIT_HIGH.
REQ-011 IDLE: on a BC_s falling edge, clear the counter and go to START.
REQ-012 START: increment the counter each cycle BC_s is low; on a BC_s rising edge, latch the count into period_reg (T), clear the bit count and go to WAIT_FALL.
REQ-013 WAIT_FALL: on a BC_s falling edge, clear the counter and go to SAMPLE.
REQ-014 SAMPLE: increment the counter; when counter == period_reg, shift BC_s into the LSB of shift_reg, increment the bit count and go to WAIT_HIGH.
REQ-015 WAIT_HIGH: when BC_s is high, go to WAIT_FALL if fewer than 8 bits are taken; otherwise complete the frame and go to IDLE.
REQ-016 Frame completion SHALL load ID from shift_reg and set ID_vld on the next clock edge.
REQ-017 The counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 In START, a saturated counter SHALL abort the frame to IDLE with ID and ID_vld unchanged.
REQ-019 A start pulse of fewer than 2 cycles (period_reg < 2) SHALL abort the frame to IDLE.
REQ-020 clr_ID_vld SHALL clear ID_vld on the next edge; ID holds its value.
REQ-021 If frame completion and clr_ID_vld occur in the same cycle, completion wins: ID is updated and ID_vld = 1.
REQ-022 A new frame completing while ID_vld = 1 SHALL overwrite ID and keep ID_vld = 1.
REQ-023 Decoding SHALL continue regardless of ID_vld; no back-pressure exists.

Reset
REQ-024 rst SHALL asynchronously force: state = IDLE; counter, period_reg, shift_reg and bit count = 0; ID = 8'h00; ID_vld = 0; all synchronizer flops = 1.
REQ-025 rst asserted mid-frame SHALL discard the partial frame.
REQ-026 After rst deasserts, the next BC_s falling edge is treated as a start pulse.

Configuration
REQ-027 Macro BARCODE_ID_FILTER_EN:
  - Defined: a completed frame with shift_reg[7:6] != 2'b00 is discarded; ID and ID_vld are unchanged.
  - Undefined: every completed frame is accepted per REQ-016.

Verification
REQ-028 T = 0x20A, send 0x15 -> ID = 0x15 and ID_vld = 1 within T+4 cycles of the 8th bit's falling edge; ID_vld stays 1 until clr_ID_vld.
REQ-029 Pulse clr_ID_vld after REQ-028 -> ID_vld = 0 next cycle and ID stays 0x15; pulse clr_ID_vld in the exact completion cycle of a second frame (0x2A) -> ID = 0x2A and ID_vld = 1.
REQ-030 T = 0x20A, send 0xC5:
  - with BARCODE_ID_FILTER_EN -> ID_vld stays 0 and ID unchanged;
  - without it -> ID = 0xC5 and ID_vld = 1.
REQ-031 Back-to-back frames 0x01 (T = 0x100) then 0x3E (T = 0x3FF) with no clr -> ID = 0x01 after the first frame, ID = 0x3E after the second, and ID_vld remains 1 throughout.
REQ-032 Assert rst after the 4th bit of 0x15, release it, then send 0x22 -> ID = 0x22 and ID_vld = 1 with no trace of the partial frame; assert rst alone -> ID = 0x00 and ID_vld = 0 asynchronously.
REQ-033 Glitch handling:
  - 1-cycle low glitch on BC -> no ID_vld;
  - BC held low for 2^CNT_W+10 cycles -> state returns to IDLE after release and no ID_vld.
